// File: rtl/pong_input_pkg.sv
// Shared definitions for the multi-player encoder/paddle input front-end.
//   quad_e / QUAD_TABLE : quadrature decode, indexed by {prev_a, prev_b, cur_a, cur_b}
//   reset_pos()         : centred paddle top row for a given screen height and length
//   clog2_int()         : ceiling log2, used for the position and counter widths
package pong_input_pkg;

    typedef enum logic [1:0] {
        Q_NONE = 2'd0,
        Q_FWD  = 2'd1,
        Q_REV  = 2'd2,
        Q_ILL  = 2'd3
    } quad_e;

    // Forward order of {A,B} is 00 -> 01 -> 11 -> 10 -> 00.
    localparam quad_e QUAD_TABLE [16] = '{
        Q_NONE, Q_FWD,  Q_REV,  Q_ILL,   // prev 00
        Q_REV,  Q_NONE, Q_ILL,  Q_FWD,   // prev 01
        Q_FWD,  Q_ILL,  Q_NONE, Q_REV,   // prev 10
        Q_ILL,  Q_REV,  Q_FWD,  Q_NONE   // prev 11
    };

    function automatic int reset_pos(input int rows, input int len);
        return (rows - len) / 2;
    endfunction

    function automatic int clog2_int(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/enc_channel.sv
// One player channel: 2-flop synchronisers, history debounce on the shared tick,
// quadrature decode, signed detent accumulator and the paddle position register.
//   clk, reset  : clock, synchronous active-low reset
//   tick        : debounce sample strobe from the shared prescaler
//   enc_a/enc_b : raw asynchronous encoder inputs
//   wide        : 1 = paddle one row longer
//   paddle      : row bitmap, bit r set = row r occupied
//   pos         : top row of the paddle
//   moved       : one-cycle pulse when pos changes
//   err         : sticky illegal-transition flag
// Build option: PADDLE_WRAP_EN makes moves and the bitmap wrap modulo SCREEN_ROWS.
module enc_channel
    import pong_input_pkg::*;
#(
    parameter int HIST_LEN          = 9,
    parameter int SCREEN_ROWS       = 16,
    parameter int PADDLE_LEN        = 3,
    parameter int QUARTERS_PER_STEP = 4,
    parameter int PW                = clog2_int(SCREEN_ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   wide,
    output logic [SCREEN_ROWS-1:0] paddle,
    output logic [PW-1:0]          pos,
    output logic                   moved,
    output logic                   err
);

    // Two spare bits: one for sign, one so +QUARTERS_PER_STEP is representable.
    localparam int AW = clog2_int(QUARTERS_PER_STEP) + 2;
    localparam logic signed [AW-1:0] ACC_MAX   = AW'(QUARTERS_PER_STEP);
    localparam logic [PW-1:0]        POS_RESET = PW'(reset_pos(SCREEN_ROWS, PADDLE_LEN));

    logic                 a_meta, a_sync, b_meta, b_sync;
    logic [HIST_LEN-1:0]  hist_a, hist_b, hist_a_next, hist_b_next;
    logic                 deb_a, deb_b;
    logic [1:0]           prev_ab;
    quad_e                quad;
    logic signed [AW-1:0] acc, acc_next, delta;
    logic                 step_dn, step_up;
    logic [PW:0]          len_w;
    logic [PW-1:0]        pos_next;

    assign hist_a_next = {hist_a[HIST_LEN-2:0], a_sync};
    assign hist_b_next = {hist_b[HIST_LEN-2:0], b_sync};
    assign quad        = QUAD_TABLE[{prev_ab, deb_a, deb_b}];
    assign len_w       = (PW+1)'(PADDLE_LEN) + (PW+1)'(wide);

    // A limit reached last clk is consumed now; a quarter arriving in the same
    // clk starts the next detent rather than being lost.
    assign step_dn  = (acc == ACC_MAX);
    assign step_up  = (acc == -ACC_MAX);
    assign acc_next = (step_dn || step_up) ? delta : acc + delta;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        delta = '0;
        case (quad)
            Q_FWD:   delta = AW'(1);
            Q_REV:   delta = '1;
            default: delta = '0;
        endcase
    end

`ifdef PADDLE_WRAP_EN
    always_comb begin
        pos_next = pos;
        if (step_dn)      pos_next = pos + PW'(1);
        else if (step_up) pos_next = pos - PW'(1);
    end

    always_comb begin
        paddle = '0;
        for (int r = 0; r < SCREEN_ROWS; r++)
            paddle[r] = ({1'b0, PW'(PW'(r) - pos)} < len_w);
    end
`else
    logic [PW:0]   max_pos;
    logic [PW-1:0] base;

    assign max_pos = (PW+1)'(SCREEN_ROWS) - len_w;

    // A paddle that just became longer while at the bottom is pulled back
    // first; any move is then applied from the clamped row with saturation.
    always_comb begin
        base     = ({1'b0, pos} > max_pos) ? max_pos[PW-1:0] : pos;
        pos_next = base;
        if (step_dn && ({1'b0, base} < max_pos)) pos_next = base + PW'(1);
        else if (step_up && (base != '0))        pos_next = base - PW'(1);
    end

    always_comb begin
        paddle = '0;
        for (int r = 0; r < SCREEN_ROWS; r++)
            paddle[r] = (r >= int'(pos)) && (r < int'(pos) + int'(len_w));
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_meta  <= 1'b0;
            a_sync  <= 1'b0;
            b_meta  <= 1'b0;
            b_sync  <= 1'b0;
            // NOTE: the histories are real state that must restart clean, so they are reset too.
            hist_a  <= '0;
            hist_b  <= '0;
            deb_a   <= 1'b0;
            deb_b   <= 1'b0;
            prev_ab <= 2'b00;
            acc     <= '0;
            pos     <= POS_RESET;
            moved   <= 1'b0;
            err     <= 1'b0;
        end else begin
            a_meta  <= enc_a;
            a_sync  <= a_meta;
            b_meta  <= enc_b;
            b_sync  <= b_meta;
            if (tick) begin
                hist_a <= hist_a_next;
                hist_b <= hist_b_next;
                if (&hist_a_next)       deb_a <= 1'b1;
                else if (~|hist_a_next) deb_a <= 1'b0;
                if (&hist_b_next)       deb_b <= 1'b1;
                else if (~|hist_b_next) deb_b <= 1'b0;
            end
            prev_ab <= {deb_a, deb_b};
            acc     <= acc_next;
            pos     <= pos_next;
            moved   <= (pos_next != pos);
            if (quad == Q_ILL) err <= 1'b1;
        end
    end

endmodule

// File: rtl/player_input_array.sv
// Multi-player input front-end: one shared debounce prescaler feeding
// NUM_PLAYERS independent encoder/paddle channels.
//   clk, reset   : clock, synchronous active-low reset
//   enc_a, enc_b : raw encoder inputs, one bit per player
//   wide         : per-player long-paddle select
//   paddle_o     : player p bitmap at [p*SCREEN_ROWS +: SCREEN_ROWS]
//   pos_o        : player p top row at [p*PW +: PW]
//   moved_o      : per-player move pulse
//   err_o        : per-player sticky illegal-transition flag
// Build option: PADDLE_WRAP_EN (see enc_channel) selects wrapping paddles.
module player_input_array
    import pong_input_pkg::*;
#(
    parameter int NUM_PLAYERS       = 2,
    parameter int HIST_LEN          = 9,
    parameter int DEB_DIV           = 7,
    parameter int SCREEN_ROWS       = 16,
    parameter int PADDLE_LEN        = 3,
    parameter int QUARTERS_PER_STEP = 4,
    localparam int PW               = clog2_int(SCREEN_ROWS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PLAYERS-1:0]             enc_a,
    input  logic [NUM_PLAYERS-1:0]             enc_b,
    input  logic [NUM_PLAYERS-1:0]             wide,
    output logic [NUM_PLAYERS*SCREEN_ROWS-1:0] paddle_o,
    output logic [NUM_PLAYERS*PW-1:0]          pos_o,
    output logic [NUM_PLAYERS-1:0]             moved_o,
    output logic [NUM_PLAYERS-1:0]             err_o
);

    localparam int CW = (DEB_DIV > 1) ? clog2_int(DEB_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    // With DEB_DIV = 1 the count never leaves 0, so tick is permanently high.
    assign tick = (cnt == CW'(DEB_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
        enc_channel #(
            .HIST_LEN          (HIST_LEN),
            .SCREEN_ROWS       (SCREEN_ROWS),
            .PADDLE_LEN        (PADDLE_LEN),
            .QUARTERS_PER_STEP (QUARTERS_PER_STEP),
            .PW                (PW)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .enc_a  (enc_a[i]),
            .enc_b  (enc_b[i]),
            .wide   (wide[i]),
            .paddle (paddle_o[i*SCREEN_ROWS +: SCREEN_ROWS]),
            .pos    (pos_o[i*PW +: PW]),
            .moved  (moved_o[i]),
            .err    (err_o[i])
        );
    end

endmodule

// File: tb/tb_player_input_array.sv
// Directed bench for player_input_array at default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_player_input_array;

    localparam int NP   = 2;
    localparam int ROWS = 16;
    localparam int PW   = 4;
    localparam int DIV  = 7;
    localparam int HOLD = 12;   // ticks each encoder phase is held

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     enc_a, enc_b, wide;
    logic [NP*ROWS-1:0] paddle_o;
    logic [NP*PW-1:0]  pos_o;
    logic [NP-1:0]     moved_o, err_o;

    int vectors     = 0;
    int miscompares = 0;
    int mv_total [NP];

    always #5 clk = ~clk;

    player_input_array dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .wide     (wide),
        .paddle_o (paddle_o),
        .pos_o    (pos_o),
        .moved_o  (moved_o),
        .err_o    (err_o)
    );

    initial for (int p = 0; p < NP; p++) mv_total[p] = 0;

    always @(posedge clk)
        for (int p = 0; p < NP; p++)
            if (moved_o[p] === 1'b1) mv_total[p]++;

    function automatic logic [PW-1:0] pos_of(input int p);
        return pos_o[p*PW +: PW];
    endfunction

    function automatic logic [ROWS-1:0] paddle_of(input int p);
        return paddle_o[p*ROWS +: ROWS];
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_phase(input int p, input logic [1:0] ab);
        enc_a[p] = ab[1];
        enc_b[p] = ab[0];
        wait_clks(HOLD * DIV);
    endtask

    task automatic detent_fwd(input int p);
        set_phase(p, 2'b01); set_phase(p, 2'b11); set_phase(p, 2'b10); set_phase(p, 2'b00);
    endtask

    task automatic detent_rev(input int p);
        set_phase(p, 2'b10); set_phase(p, 2'b11); set_phase(p, 2'b01); set_phase(p, 2'b00);
    endtask

    task automatic test_reset;
        reset = 1'b0; enc_a = '0; enc_b = '0; wide = '0;
        wait_clks(3);
        reset = 1'b1;
        wait_clks(1);
        vectors++; if (pos_of(0) !== 4'd6) begin miscompares++; $display("FAIL reset_pos0: got %0d expected 6", pos_of(0)); end
        vectors++; if (pos_of(1) !== 4'd6) begin miscompares++; $display("FAIL reset_pos1: got %0d expected 6", pos_of(1)); end
        vectors++; if (paddle_of(0) !== 16'h01C0) begin miscompares++; $display("FAIL reset_paddle0: got %h expected 01c0", paddle_of(0)); end
        vectors++; if (moved_o !== 2'b00) begin miscompares++; $display("FAIL reset_moved: got %b expected 00", moved_o); end
        vectors++; if (err_o !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b expected 00", err_o); end
    endtask

    task automatic test_debounce;
        int c;
        int m0;
        m0 = mv_total[0];
        enc_a[0] = 1'b1;
        wait_clks(5 * DIV);
        enc_a[0] = 1'b0;
        wait_clks(HOLD * DIV);
        vectors++; if (dut.g_ch[0].u_ch.deb_a !== 1'b0) begin miscompares++; $display("FAIL glitch_deb_a: got %b expected 0", dut.g_ch[0].u_ch.deb_a); end
        // Stable high: 2 sync clks, then the 9th tick seeing 1 lands on clk 59..65.
        enc_a[0] = 1'b1;
        c = 0;
        while (dut.g_ch[0].u_ch.deb_a !== 1'b1 && c < 80) begin
            @(negedge clk);
            c++;
        end
        vectors++; if (c < 59 || c > 65) begin miscompares++; $display("FAIL deb_latency: got %0d clks expected 59..65", c); end
        enc_a[0] = 1'b0;
        wait_clks(HOLD * DIV);
        vectors++; if (pos_of(0) !== 4'd6) begin miscompares++; $display("FAIL deb_pos0: got %0d expected 6", pos_of(0)); end
        vectors++; if (mv_total[0] - m0 !== 0) begin miscompares++; $display("FAIL deb_moves: got %0d expected 0", mv_total[0] - m0); end
    endtask

    task automatic test_step;
        int m1;
        m1 = mv_total[1];
        detent_fwd(1);
        vectors++; if (pos_of(1) !== 4'd7) begin miscompares++; $display("FAIL step_fwd_pos1: got %0d expected 7", pos_of(1)); end
        vectors++; if (mv_total[1] - m1 !== 1) begin miscompares++; $display("FAIL step_fwd_moves: got %0d expected 1", mv_total[1] - m1); end
        vectors++; if (pos_of(0) !== 4'd6) begin miscompares++; $display("FAIL step_other_pos0: got %0d expected 6", pos_of(0)); end
        detent_rev(1);
        vectors++; if (pos_of(1) !== 4'd6) begin miscompares++; $display("FAIL step_rev_pos1: got %0d expected 6", pos_of(1)); end
        vectors++; if (paddle_of(1) !== 16'h01C0) begin miscompares++; $display("FAIL step_rev_paddle1: got %h expected 01c0", paddle_of(1)); end
    endtask

    task automatic test_reversal;
        int m1;
        m1 = mv_total[1];
        set_phase(1, 2'b01); set_phase(1, 2'b11); set_phase(1, 2'b01); set_phase(1, 2'b00);
        vectors++; if (pos_of(1) !== 4'd6) begin miscompares++; $display("FAIL reversal_pos1: got %0d expected 6", pos_of(1)); end
        vectors++; if (mv_total[1] - m1 !== 0) begin miscompares++; $display("FAIL reversal_moves: got %0d expected 0", mv_total[1] - m1); end
    endtask

`ifndef PADDLE_WRAP_EN
    task automatic test_saturation;
        int m0;
        m0 = mv_total[0];
        repeat (20) detent_fwd(0);
        vectors++; if (pos_of(0) !== 4'd13) begin miscompares++; $display("FAIL sat_pos0: got %0d expected 13", pos_of(0)); end
        vectors++; if (paddle_of(0) !== 16'hE000) begin miscompares++; $display("FAIL sat_paddle0: got %h expected e000", paddle_of(0)); end
        vectors++; if (mv_total[0] - m0 !== 7) begin miscompares++; $display("FAIL sat_moves: got %0d expected 7", mv_total[0] - m0); end
        m0 = mv_total[0];
        wide[0] = 1'b1;
        wait_clks(4);
        vectors++; if (pos_of(0) !== 4'd12) begin miscompares++; $display("FAIL wide_pos0: got %0d expected 12", pos_of(0)); end
        vectors++; if (paddle_of(0) !== 16'hF000) begin miscompares++; $display("FAIL wide_paddle0: got %h expected f000", paddle_of(0)); end
        vectors++; if (mv_total[0] - m0 !== 1) begin miscompares++; $display("FAIL wide_moves: got %0d expected 1", mv_total[0] - m0); end
    endtask
`else
    task automatic test_wrap;
        repeat (7) detent_fwd(0);
        vectors++; if (pos_of(0) !== 4'd13) begin miscompares++; $display("FAIL wrap_pos13: got %0d expected 13", pos_of(0)); end
        detent_fwd(0);
        vectors++; if (pos_of(0) !== 4'd14) begin miscompares++; $display("FAIL wrap_pos14: got %0d expected 14", pos_of(0)); end
        vectors++; if (paddle_of(0) !== 16'hC001) begin miscompares++; $display("FAIL wrap_paddle14: got %h expected c001", paddle_of(0)); end
        detent_fwd(0);
        vectors++; if (pos_of(0) !== 4'd15) begin miscompares++; $display("FAIL wrap_pos15: got %0d expected 15", pos_of(0)); end
        vectors++; if (paddle_of(0) !== 16'h8003) begin miscompares++; $display("FAIL wrap_paddle15: got %h expected 8003", paddle_of(0)); end
    endtask
`endif

    task automatic test_illegal(input logic [PW-1:0] exp_pos);
        enc_a[0] = 1'b1;
        enc_b[0] = 1'b1;
        wait_clks(HOLD * DIV);
        vectors++; if (err_o[0] !== 1'b1) begin miscompares++; $display("FAIL ill_err0: got %b expected 1", err_o[0]); end
        vectors++; if (err_o[1] !== 1'b0) begin miscompares++; $display("FAIL ill_err1: got %b expected 0", err_o[1]); end
        vectors++; if (pos_of(0) !== exp_pos) begin miscompares++; $display("FAIL ill_pos0: got %0d expected %0d", pos_of(0), exp_pos); end
        enc_a[0] = 1'b0;
        enc_b[0] = 1'b0;
        wait_clks(HOLD * DIV);
        vectors++; if (err_o[0] !== 1'b1) begin miscompares++; $display("FAIL ill_err0_sticky: got %b expected 1", err_o[0]); end
        vectors++; if (pos_of(0) !== exp_pos) begin miscompares++; $display("FAIL ill_pos0_after: got %0d expected %0d", pos_of(0), exp_pos); end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_step;
        test_reversal;
`ifndef PADDLE_WRAP_EN
        test_saturation;
        test_illegal(4'd12);
`else
        test_wrap;
        test_illegal(4'd15);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
